// File: rtl/err_gen_if.sv
// Sample-in / error-out bundle between the sensor front end and the PID term blocks.
interface err_gen_if;
  logic        en;
  logic        smpl_vld;
  logic [11:0] smpl;
  logic [11:0] desired;
  logic [9:0]  err_sat;
  logic        err_vld;
  logic        sat_flg;
  logic        stale;

  modport master (
    output en, smpl_vld, smpl, desired,
    input  err_sat, err_vld, sat_flg, stale
  );

  modport slave (
    input  en, smpl_vld, smpl, desired,
    output err_sat, err_vld, sat_flg, stale
  );
endinterface

// File: rtl/err_gen.sv
// PID error front end: windowed sample average minus setpoint, saturated to 10-bit signed,
// with clip flag and stalled-stream detect.
module err_gen #(
  parameter int AVG_LOG2 = 2,
  parameter int TMO_W    = 16
) (
  input logic      clk,
  input logic      rst,
  err_gen_if.slave bus
);
  localparam int ACC_W = 12 + AVG_LOG2;
  // Keep cnt at least one bit wide; with AVG_LOG2 = 0 it stays 0 and every sample is final.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc, sum_q, acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       vld_pipe;   // [0]: sum_q valid, [1]: err_sat valid
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic [11:0]      avg;
  logic signed [12:0] diff;
  logic [9:0]       sat_c;
  logic             flg_c;
  logic             accept, last;
  logic [9:0]       err_sat_q;
  logic             sat_flg_q, stale_q;

  assign accept  = bus.en & bus.smpl_vld;
  assign last    = (cnt == CNT_LAST);
  assign acc_sum = acc + ACC_W'(bus.smpl);

  // Average is a truncating shift; difference needs one extra bit for sign.
  assign avg  = 12'(sum_q >> AVG_LOG2);
  assign diff = $signed({1'b0, avg}) - $signed({1'b0, bus.desired});

  always_comb begin
    sat_c = diff[9:0];
    flg_c = 1'b0;
    if (diff > 13'sd511) begin
      sat_c = 10'h1FF;
      flg_c = 1'b1;
    end else if (diff < -13'sd512) begin
      sat_c = 10'h200;
      flg_c = 1'b1;
    end
  end

  always_comb begin
    tmo_nxt = tmo;
    if (accept)      tmo_nxt = '0;
    else if (~&tmo)  tmo_nxt = tmo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      sum_q     <= '0;
      vld_pipe  <= '0;
      tmo       <= '0;
      stale_q   <= 1'b0;
      err_sat_q <= '0;
      sat_flg_q <= 1'b0;
    end else if (!bus.en) begin
      // Partial window and in-flight results are dropped; last result is kept.
      acc      <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
      tmo      <= '0;
      stale_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept & last};
      if (accept) begin
        if (last) begin
          sum_q <= acc_sum;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (vld_pipe[0]) begin
        err_sat_q <= sat_c;
        sat_flg_q <= flg_c;
      end
      tmo     <= tmo_nxt;
      stale_q <= &tmo_nxt;
    end
  end

  assign bus.err_sat = err_sat_q;
  assign bus.sat_flg = sat_flg_q;
  assign bus.err_vld = vld_pipe[1];
  assign bus.stale   = stale_q;
endmodule

// File: tb/tb_err_gen.sv
// Directed bench for err_gen: scoreboard of expected results, monitor pops on err_vld.
module tb_err_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [9:0] sat;
    logic       flg;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  err_gen_if bus();

  err_gen #(.AVG_LOG2(2), .TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic strobe(input logic [11:0] v);
    @(negedge clk);
    bus.en       = 1'b1;
    bus.smpl_vld = 1'b1;
    bus.smpl     = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.smpl_vld = 1'b0;
    end
  endtask

  // Called right after the final strobe is driven; result due two edges later.
  task automatic expect_res(input logic [9:0] s, input logic f);
    exp_t e;
    e.sat = s;
    e.flg = f;
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic window(input logic [11:0] v, input logic [11:0] d,
                        input logic [9:0] s, input logic f);
    bus.desired = d;
    repeat (4) strobe(v);
    expect_res(s, f);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (bus.err_vld) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_err_vld: err_sat %h at cyc %0d, none expected", bus.err_sat, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_sat", 32'(bus.err_sat), 32'(e.sat));
        chk("sat_flg", 32'(bus.sat_flg), 32'(e.flg));
        chk("err_vld_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.en       = 1'b0;
    bus.smpl_vld = 1'b0;
    bus.smpl     = '0;
    bus.desired  = '0;
    repeat (3) @(negedge clk);
    chk("rst_err_sat", 32'(bus.err_sat), 0);
    chk("rst_err_vld", 32'(bus.err_vld), 0);
    chk("rst_sat_flg", 32'(bus.sat_flg), 0);
    chk("rst_stale",   32'(bus.stale), 0);
    rst    = 1'b0;
    bus.en = 1'b1;

    // Nominal: 2148 avg - 2048 = 100
    window(12'h864, 12'h800, 10'h064, 1'b0);

    // Truncation with gaps: sum 10 >> 2 = 2
    bus.desired = 12'h000;
    strobe(12'd1); idle(2);
    strobe(12'd2); idle(1);
    strobe(12'd3); idle(3);
    strobe(12'd4);
    expect_res(10'h002, 1'b0);
    idle(3);
    window(12'h200, 12'h000, 10'h1FF, 1'b1);

    // Saturation corners
    window(12'hFFF, 12'h000, 10'h1FF, 1'b1);
    window(12'h000, 12'hFFF, 10'h200, 1'b1);
    window(12'h200, 12'h400, 10'h200, 1'b0);

    // Continuous stream: three windows back to back, results 4 cycles apart
    bus.desired = 12'h800;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) strobe(12'h810 + 12'(w * 16));
      expect_res(10'(16 * (w + 1)), 1'b0);
    end
    idle(4);

    // Abort: partial window discarded by en low
    strobe(12'h123);
    strobe(12'h123);
    @(negedge clk);
    bus.en       = 1'b0;
    bus.smpl_vld = 1'b0;
    window(12'h810, 12'h800, 10'h010, 1'b0);

    // en falls with stage 1 valid: result killed, outputs hold
    bus.desired = 12'h800;
    repeat (4) strobe(12'h900);
    @(negedge clk);
    bus.en       = 1'b0;
    bus.smpl_vld = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    idle(4);
    chk("en_kill_hold_err_sat", 32'(bus.err_sat), 32'h010);

    // rst right after the final strobe
    window(12'hFFF, 12'h000, 10'h1FF, 1'b1);
    bus.desired = 12'h000;
    repeat (4) strobe(12'hFFF);
    @(negedge clk);
    rst          = 1'b1;
    bus.smpl_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("rst_mid_err_sat", 32'(bus.err_sat), 0);
    chk("rst_mid_sat_flg", 32'(bus.sat_flg), 0);
    chk("rst_mid_err_vld", 32'(bus.err_vld), 0);

    // Stale: rises 15 edges after the accepting edge, clears after next accept
    strobe(12'h001);
    idle(1);
    repeat (14) @(negedge clk);
    chk("stale_before", 32'(bus.stale), 0);
    @(negedge clk);
    chk("stale_rise", 32'(bus.stale), 1);
    strobe(12'h002);
    idle(1);
    chk("stale_clear", 32'(bus.stale), 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
